// File: rtl/byte_unpack_pkg.sv
// Shared types and sizing helpers for the byte stream unpacker.
package byte_unpack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int COUNT_W = 32;
  localparam int GAP_W   = 8;

  // Width of a byte-length field able to hold 0..data_w/8.
  function automatic int len_w(input int data_w);
    return $clog2(data_w / 8 + 1);
  endfunction

endpackage

// File: rtl/byte_unpack_fifo.sv
// Word FIFO holding {len, data} entries; show-ahead read, async active-high reset.
module byte_unpack_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/byte_stream_unpacker.sv
// Unpacks queued multi-byte words into a one-byte-per-cycle strobe stream, LSB first.
// Optional build macro BYTE_UNPACK_NUL_DROP_EN: 8'h00 bytes keep their slot but
// raise no strobe and are not counted.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no word in flight; pops the FIFO head when one is present
// EMIT    | presenting sh_q[7:0] on out_byte for exactly one cycle
// GAP     | pacing idle after a byte; gap_q counts down to the next slot
module byte_stream_unpacker
  import byte_unpack_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 0,
  localparam int LEN_W     = len_w(DATA_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [LEN_W-1:0]    in_len,
  output logic                out_valid,
  output logic [7:0]          out_byte,
  output logic [COUNT_W-1:0]  byte_count,
  output logic                busy
);

  localparam int NBYTES = DATA_W / 8;
  localparam int WORD_W = LEN_W + DATA_W;
  localparam logic [LEN_W-1:0]   NBYTES_L = LEN_W'(NBYTES);
  localparam logic [LEN_W-1:0]   LEN_ONE  = LEN_W'(1);
  localparam logic [GAP_W-1:0]   GAP_L    = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0]   GAP_ONE  = GAP_W'(1);
  localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [COUNT_W-1:0]  bc_q, bc_d;
  logic                out_valid_q, out_valid_d;
  logic [7:0]          out_byte_q, out_byte_d;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic                fifo_push;
  logic [WORD_W-1:0]   fifo_rdata;
  logic [LEN_W-1:0]    head_len;
  logic [LEN_W-1:0]    head_len_c;
  logic [DATA_W-1:0]   head_data;

  // A byte raises a strobe unless NUL bytes are being suppressed.
  function automatic logic byte_visible(input logic [7:0] b);
`ifdef BYTE_UNPACK_NUL_DROP_EN
    return (b != 8'h00);
`else
    return 1'b1;
`endif
  endfunction

  assign in_ready  = !fifo_full && !reset;
  assign fifo_push = in_valid && in_ready;

  byte_unpack_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i ({in_len, in_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_len   = fifo_rdata[WORD_W-1 -: LEN_W];
  assign head_data  = fifo_rdata[DATA_W-1:0];
  assign head_len_c = (head_len > NBYTES_L) ? NBYTES_L : head_len;

  // Next-state decode; a pop always reloads sh/cnt and a zero-length head falls back to IDLE.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    bc_d     = bc_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = head_data;
          cnt_d    = head_len_c;
          state_d  = (head_len_c == '0) ? ST_IDLE : ST_EMIT;
        end
      end

      ST_EMIT: begin
        if (out_valid_q) bc_d = bc_q + CNT_ONE;
        sh_d  = sh_q >> 8;
        cnt_d = cnt_q - LEN_ONE;
        if (GAP_CYCLES > 0) begin
          state_d = ST_GAP;
          gap_d   = GAP_L;
        end else if (cnt_q > LEN_ONE) begin
          state_d = ST_EMIT;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = head_data;
          cnt_d    = head_len_c;
          state_d  = (head_len_c == '0) ? ST_IDLE : ST_EMIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GAP: begin
        gap_d = gap_q - GAP_ONE;
        if (gap_q <= GAP_ONE) begin
          if (cnt_q != '0) begin
            state_d = ST_EMIT;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sh_d     = head_data;
            cnt_d    = head_len_c;
            state_d  = (head_len_c == '0) ? ST_IDLE : ST_EMIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    out_valid_d = (state_d == ST_EMIT) && byte_visible(sh_d[7:0]);
    out_byte_d  = (state_d == ST_EMIT) ? sh_d[7:0] : out_byte_q;
  end

  // FSM and registered outputs; reset discards any partially emitted word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      bc_q        <= '0;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      bc_q        <= bc_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_byte   = out_byte_q;
  assign byte_count = bc_q;
  assign busy       = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_byte_stream_unpacker.sv
// Bench for byte_stream_unpacker: an unpaced instance and a GAP_CYCLES=2 instance,
// checked against a byte-slot queue model built from accepted words.
module tb_byte_stream_unpacker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v = 1'b0;
  logic [63:0] din = '0;
  logic [3:0]  lin = '0;
  int          sel = 0;

  logic        va, vb, rdy_a, rdy_b, ov_a, ov_b, busy_a, busy_b;
  logic [7:0]  ob_a, ob_b;
  logic [31:0] bc_a, bc_b;
  logic        rdy, ov, bsy;
  logic [7:0]  ob;
  logic [31:0] bc;

  assign va  = v && (sel == 0);
  assign vb  = v && (sel == 1);
  assign rdy = (sel == 0) ? rdy_a  : rdy_b;
  assign ov  = (sel == 0) ? ov_a   : ov_b;
  assign ob  = (sel == 0) ? ob_a   : ob_b;
  assign bc  = (sel == 0) ? bc_a   : bc_b;
  assign bsy = (sel == 0) ? busy_a : busy_b;

  byte_stream_unpacker #(.DATA_W(64), .DEPTH(4), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(va), .in_ready(rdy_a), .in_data(din), .in_len(lin),
    .out_valid(ov_a), .out_byte(ob_a), .byte_count(bc_a), .busy(busy_a));

  byte_stream_unpacker #(.DATA_W(64), .DEPTH(4), .GAP_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(vb), .in_ready(rdy_b), .in_data(din), .in_len(lin),
    .out_valid(ov_b), .out_byte(ob_b), .byte_count(bc_b), .busy(busy_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] obs_b[$];
  int         obs_c[$];
  logic [7:0] slot_q[$];
  int         stray = 0;

  always @(negedge clk) begin
    if (!reset && ov) begin
      obs_b.push_back(ob);
      obs_c.push_back(cyc);
    end
    if (!reset && ((sel == 0) ? ov_b : ov_a)) stray++;
  end

  int n_checks = 0;
  int n_fail = 0;
  int hs_cyc = 0;
  int stalls = 0;
  int exp_bc_a = 0;
  int exp_bc_b = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit visible(input logic [7:0] b);
`ifdef BYTE_UNPACK_NUL_DROP_EN
    return b != 8'h00;
`else
    return 1'b1;
`endif
  endfunction

  task automatic push_word(input logic [63:0] d, input logic [3:0] l);
    int n;
    int nb;
    n = 0;
    v = 1'b1; din = d; lin = l;
    while (!rdy && n < 200) begin
      stalls++;
      @(posedge clk); #1;
      n++;
    end
    check_eq("push_timeout", 64'(n >= 200), 64'd0);
    hs_cyc = cyc;
    nb = (l > 4'd8) ? 8 : int'(l);
    for (int i = 0; i < nb; i++) slot_q.push_back(d[8*i +: 8]);
    @(posedge clk); #1;
    v = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (bsy && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_timeout", 64'(n >= 3000), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // p < 0 skips the slot timing check; slot j is expected at p+2+j*(g+1).
  task automatic check_stream(input string tag, input int p, input int g);
    int k;
    int exp_n;
    k = 0; exp_n = 0;
    for (int j = 0; j < slot_q.size(); j++) begin
      if (visible(slot_q[j])) begin
        exp_n++;
        if (k < obs_b.size()) begin
          check_eq($sformatf("%s_byte%0d", tag, j), 64'(obs_b[k]), 64'(slot_q[j]));
          if (p >= 0)
            check_eq($sformatf("%s_cyc%0d", tag, j), 64'(obs_c[k]), 64'(p + 2 + j * (g + 1)));
        end
        k++;
      end
    end
    check_eq({tag, "_count"}, 64'(obs_b.size()), 64'(exp_n));
    if (sel == 0) begin
      exp_bc_a += exp_n;
      check_eq({tag, "_bytecount"}, 64'(bc), 64'(exp_bc_a));
    end else begin
      exp_bc_b += exp_n;
      check_eq({tag, "_bytecount"}, 64'(bc), 64'(exp_bc_b));
    end
    obs_b.delete(); obs_c.delete(); slot_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int p;
    int n;
    logic [3:0] l;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 64'(rdy), 64'd0);
    check_eq("rst_out_valid", 64'(ov), 64'd0);
    check_eq("rst_out_byte", 64'(ob), 64'd0);
    check_eq("rst_byte_count", 64'(bc), 64'd0);
    check_eq("rst_busy", 64'(bsy), 64'd0);
    reset = 1'b0;
    #1;
    check_eq("rel_in_ready", 64'(rdy), 64'd1);
    @(posedge clk); #1;

    // single word, seven bytes
    push_word(64'h000A_216F_6C6C_6548, 4'd7);
    p = hs_cyc;
    drain();
    check_stream("single", p, 0);

    // back-to-back words across the boundary
    push_word({$urandom, $urandom}, 4'd8);
    p = hs_cyc;
    push_word({$urandom, $urandom}, 4'd3);
    drain();
    check_stream("b2b", p, 0);

    // burst beyond FIFO depth
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      push_word({$urandom, $urandom}, 4'd8);
      if (i == 0) p = hs_cyc;
    end
    check_eq("bp_stalled", 64'(stalls > 0), 64'd1);
    drain();
    check_stream("burst", p, 0);

    // NUL byte in the middle
    push_word(64'h0000_0000_0042_0041, 4'd3);
    p = hs_cyc;
    drain();
    check_stream("nul", p, 0);

    // reset while the third byte is on the output
    push_word(64'h1112_1314_1516_1718, 4'd8);
    n = 0;
    while (obs_b.size() < 3 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("mid_third_seen", 64'(obs_b.size()), 64'd3);
    reset = 1'b1;
    #1;
    check_eq("mid_out_valid", 64'(ov), 64'd0);
    check_eq("mid_byte_count", 64'(bc), 64'd0);
    check_eq("mid_busy", 64'(bsy), 64'd0);
    check_eq("mid_in_ready", 64'(rdy), 64'd0);
    obs_b.delete(); obs_c.delete(); slot_q.delete();
    exp_bc_a = 0; exp_bc_b = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("post_rst_quiet", 64'(obs_b.size()), 64'd0);
    check_eq("post_rst_busy", 64'(bsy), 64'd0);
    check_eq("post_rst_ready", 64'(rdy), 64'd1);

    // random words, lengths 0..15, random idle spacing
    for (int i = 0; i < 40; i++) begin
      l = 4'($urandom_range(0, 15));
      push_word({$urandom, $urandom}, l);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    check_stream("rand_a", -1, 0);

    // paced instance
    sel = 1;
    @(posedge clk); #1;
    push_word({$urandom, $urandom}, 4'd0);
    drain();
    check_stream("len0", -1, 2);
    push_word(64'h0000_0000_0000_3231, 4'd2);
    p = hs_cyc;
    drain();
    check_stream("gap2", p, 2);
    push_word(64'h0000_0000_0053_5251, 4'd3);
    p = hs_cyc;
    push_word(64'h0000_0000_0000_6261, 4'd2);
    drain();
    check_stream("gap_b2b", p, 2);
    for (int i = 0; i < 20; i++) begin
      l = 4'($urandom_range(0, 15));
      push_word({$urandom, $urandom}, l);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();
    check_stream("rand_b", -1, 2);

    check_eq("stray_strobes", 64'(stray), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_stream_unpacker.md
Name: byte_stream_unpacker

Overview:
- Sits directly upstream of the simulation byte printer.
- Accepts packed multi-byte words over a valid/ready interface, buffers them in a small word FIFO, and emits one byte per cycle, LSB first.
- Output is an in_valid/in_byte pair with no backpressure, fed straight into the printer.
- Optional inter-byte pacing and a running emitted-byte counter are provided for debug visibility.

Parameters:
- DATA_W, 64: input word width in bits; multiple of 8, at least 8. NBYTES = DATA_W/8.
- DEPTH, 4: word FIFO depth; power of two, at least 2.
- GAP_CYCLES, 0: idle cycles inserted after every emitted byte (0..255).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  FIFO can accept a word
- in_data  input  DATA_W  packed bytes; byte 0 in bits [7:0]
- in_len  input  $clog2(NBYTES+1)  number of valid bytes, 0..NBYTES
- out_valid  output  1  byte strobe to printer
- out_byte  output  8  byte value, meaningful only when out_valid
- byte_count  output  32  total bytes emitted; wraps modulo 2^32
- busy  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- One clock, clk. Reset is asynchronous and active-high: all state clears immediately on reset assertion.
- Reset values:
  - in_ready=0 while reset is high, 1 on the first cycle after release
  - out_valid=0, out_byte=8'h00, byte_count=0, busy=0
  - FIFO empty, FSM in IDLE
- Push:
  - Push occurs when in_valid && in_ready; in_ready = !fifo_full.
  - When the FIFO is full, a pop in the same cycle does NOT raise in_ready (no combinational full-bypass).
- Pop: the FIFO stores {in_len, in_data}; words leave in strict order.
- FSM states: IDLE, EMIT, GAP.
  - IDLE: if FIFO non-empty, pop into shift register sh and set cnt=len.
    - len==0: word discarded, stay IDLE.
    - len>NBYTES: clamp to NBYTES.
    - Otherwise go EMIT.
  - EMIT:
    - out_valid=1, out_byte=sh[7:0] (both driven from registers, no combinational path from inputs).
    - Next cycle: sh>>=8, cnt-=1, byte_count+=1.
    - If GAP_CYCLES>0, go GAP with gap counter = GAP_CYCLES.
    - Else if cnt>1, stay EMIT.
    - Else (last byte): if FIFO non-empty, pop and reload in the same cycle and stay EMIT (gapless back-to-back); otherwise go IDLE.
    - A reloaded word with len==0 goes to IDLE.
  - GAP:
    - out_valid=0; gap counter decrements.
    - On reaching 0: go EMIT if cnt>0, else follow the IDLE pop rule.
- Latency: word pushed at cycle N into an empty FIFO → popped at N+1 → first out_valid at N+2.
- Throughput: 1 byte/cycle with GAP_CYCLES=0, including across word boundaries.
- byte_count wraps from 32'hFFFF_FFFF to 0 without a flag.
- busy=0 only when the FIFO is empty and the FSM is in IDLE.
- Reset asserted mid-word: the partial word and all FIFO contents are lost; no byte is emitted after reset release until a new push.

Optional Feature:
- Macro: BYTE_UNPACK_NUL_DROP_EN.
- Defined: a byte equal to 8'h00 still consumes its EMIT slot, but out_valid stays 0 and byte_count does not increment. Gap timing is unchanged.
- Undefined: 8'h00 is emitted like any other byte.

Decomposition:
- Package byte_unpack_pkg holds:
  - state enum (IDLE, EMIT, GAP)
  - LEN_W function of DATA_W
  - COUNT_W=32
- Sub-module byte_unpack_fifo: a DEPTH x (LEN_W+DATA_W) synchronous FIFO with full/empty flags and asynchronous reset; instantiated once.

Test Plan:
- Single word, DATA_W=64: in_data=64'h0A21_6F6C_6C65_48, len=7 pushed at cycle 10 → out_valid high on cycles 12–18 with bytes 48,65,6C,6C,6F,21,0A; byte_count=7.
- Back-to-back: two words, len=8 and len=3, pushed on consecutive cycles → 11 consecutive out_valid cycles, no bubble at the boundary.
- Backpressure: DEPTH=4, push 6 words with len=8 in a burst → in_ready low after the 4th accepted word plus pop slack; all 48 bytes emitted in order; no word lost or duplicated.
- Edge lengths and pacing: len=0 word → discarded, no out_valid. Then GAP_CYCLES=2 with len=2 → out_valid pattern 1,0,0,1.
- Reset mid-emit: assert reset during the 3rd byte of a len=8 word → out_valid=0 immediately; byte_count=0; after release no output until a new push.
- NUL drop: with BYTE_UNPACK_NUL_DROP_EN, bytes 41,00,42 → strobes only for 41 and 42; byte_count=2. Without the macro: 3 strobes, byte_count=3.
